add_compare_select: RTL
=======================

Name: add_compare_select

Overview:
- Radix-2 add-compare-select (ACS) stage of the K=3, rate-1/2 Viterbi decoder, 4 trellis states.
- Sits directly downstream of the branch metric unit and consumes its 8 Hamming-distance branch metrics per trellis step.
- Keeps registered, normalized path metrics and emits per-step survivor decision bits, the best state and a step count to the traceback/survivor memory stage.

Parameters:
- BM_W, 2, width of each branch metric.
- PM_W, 6, width of each path metric register.
- INIT_PM, 32, initial metric for states 1..3 at frame start. Must be < 2^PM_W.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-low reset
- en_add  input  1  one trellis step per cycle while high; branch metrics valid
- i_start  input  1  frame start; reinitialize metrics (sampled only with en_add=1)
- i_HD  input  8*BM_W  packed branch metrics; metric j at [BM_W*j+BM_W-1 : BM_W*j]
- o_survivor  output  4  decision bit per next state n (bit n)
- o_best_state  output  2  state with minimum new path metric
- o_pm  output  4*PM_W  packed normalized path metrics, state n at [PM_W*n+PM_W-1 : PM_W*n]
- o_step_cnt  output  16  trellis steps processed since frame start
- o_valid  output  1  outputs updated this cycle (1-cycle pulse per step)

Behaviour:
- Reset (rst=0 at clk edge):
  - PM = {0, INIT_PM, INIT_PM, INIT_PM} for states 0..3.
  - o_survivor=0, o_best_state=0, o_step_cnt=0, o_valid=0.
  - Reset has priority over every other input, including mid-frame operation.
- Trellis: state s={s1,s0}, input u, next n={u,s1}.
  - Predecessors of n: p_k={n[0],k}, k∈{0,1}.
  - Branch metric index j = 2*n + k.
- Base metrics per step:
  - When en_add=1 and i_start=1, the step uses the init metrics as base, not the stored PM.
  - Otherwise the base is the stored PM.
- Add: cand_k = base[p_k] + BM[j], computed at PM_W+1 bits, then saturated to 2^PM_W-1.
- Compare/select:
  - new[n] = min(cand_0, cand_1); survivor bit n = 1 iff cand_1 < cand_0.
  - Tie selects k=0.
- Normalize: m = min over new[0..3]; stored PM[n] = new[n] - m, so at least one state always holds 0.
- Best state: lowest index n with new[n]==m.
- Latency: o_survivor, o_pm, o_best_state and o_valid are registered and update 1 cycle after the en_add edge. o_pm shows normalized values.
- o_valid: high exactly for cycles following an en_add=1 edge. Back-to-back en_add gives continuous o_valid.
- en_add=0: PM, o_survivor, o_best_state and o_step_cnt hold; o_valid=0. i_HD is ignored.
- o_step_cnt:
  - Set to 1 on a start step; otherwise incremented on each en_add step.
  - Saturates at 16'hFFFF (no wrap).
- i_start with en_add=0: ignored.
- Simultaneous i_start and en_add: that step is the first step of the new frame, using init metrics as base.

Test Plan:
- Reset then en_add=1, i_start=1, i_HD all 0 -> o_pm={0,32,0,32} (states 0..3), o_survivor=0000, o_best_state=0, o_step_cnt=1, o_valid=1 next cycle.
- Encoder-clean stream for input bits 1,0,1,1 (symbols 11,10,00,01, metrics from ideal HD table) -> o_best_state sequence 2,1,2,3; best metric always 0; o_survivor matches the true predecessor.
- Single symbol error injected at step 2 of the clean stream -> best path metric 0 after normalization, best_state still tracks the true path by step 4; no saturation.
- Every cycle, all i_HD metrics=3 for 40 steps -> PM stays equal with no overflow; all survivors 0 by tie rule; o_step_cnt=40.
- en_add toggled 1,0,0,1 -> outputs hold during the 0 cycles, o_valid pulses twice, o_step_cnt advances by 2 only.
- rst=0 asserted mid-frame after 10 steps -> next cycle PM={0,32,32,32}, counters 0, o_valid=0. i_start with en_add=0 -> no state change.

Source files
------------

// File: rtl/add_compare_select.sv
// Radix-2 add-compare-select stage for a K=3, rate-1/2 Viterbi decoder (4 states).
// Consumes 8 branch metrics per trellis step and keeps normalized path metrics.
// Each step emits one survivor bit per next state, the best state and a step count.
// Trellis: next n = {u, s1}; its predecessors are p_k = {n[0], k}, using metric 2*n+k.
module add_compare_select #(
  parameter int BM_W    = 2,
  parameter int PM_W    = 6,
  parameter int INIT_PM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_add,
  input  logic              i_start,
  input  logic [8*BM_W-1:0] i_HD,
  output logic [3:0]        o_survivor,
  output logic [1:0]        o_best_state,
  output logic [4*PM_W-1:0] o_pm,
  output logic [15:0]       o_step_cnt,
  output logic              o_valid
);

  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

  // Add at PM_W+1 bits and clamp, so a large start metric never wraps to a small one.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [BM_W-1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + (PM_W+1)'(b);
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  function automatic logic [PM_W-1:0] min2(input logic [PM_W-1:0] a,
                                           input logic [PM_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  // The step counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [4*PM_W-1:0] base_p0;
  logic [4*PM_W-1:0] cand0_p0;
  logic [4*PM_W-1:0] cand1_p0;
  logic [4*PM_W-1:0] new_p0;
  logic [4*PM_W-1:0] norm_p0;
  logic [3:0]        surv_p0;
  logic [PM_W-1:0]   min_p0;
  logic [1:0]        best_p0;

  logic [4*PM_W-1:0] pm_p1;
  logic [3:0]        surv_p1;
  logic [1:0]        best_p1;
  logic [15:0]       cnt_p1;
  logic              vld_p1;

  // Stage p0: pick base metrics; a start step restarts from the init metrics.
  always_comb begin
    if (en_add && i_start) begin
      base_p0 = {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
    end else begin
      base_p0 = pm_p1;
    end
  end

  // Add-compare-select for every next state; ties keep the k=0 predecessor.
  always_comb begin
    cand0_p0 = '0;
    cand1_p0 = '0;
    new_p0   = '0;
    surv_p0  = '0;
    for (int n = 0; n < 4; n++) begin
      cand0_p0[PM_W*n +: PM_W] = sat_add(base_p0[PM_W*(2*(n%2))   +: PM_W],
                                         i_HD[BM_W*(2*n)   +: BM_W]);
      cand1_p0[PM_W*n +: PM_W] = sat_add(base_p0[PM_W*(2*(n%2)+1) +: PM_W],
                                         i_HD[BM_W*(2*n+1) +: BM_W]);
      surv_p0[n +: 1] = (cand1_p0[PM_W*n +: PM_W] < cand0_p0[PM_W*n +: PM_W]);
      new_p0[PM_W*n +: PM_W] = surv_p0[n +: 1] ? cand1_p0[PM_W*n +: PM_W]
                                               : cand0_p0[PM_W*n +: PM_W];
    end
  end

  // Find the minimum new metric, its lowest-index state, and subtract it out.
  always_comb begin
    min_p0 = min2(min2(new_p0[0 +: PM_W],      new_p0[PM_W +: PM_W]),
                  min2(new_p0[2*PM_W +: PM_W], new_p0[3*PM_W +: PM_W]));
    if (new_p0[0 +: PM_W] == min_p0) begin
      best_p0 = 2'd0;
    end else if (new_p0[PM_W +: PM_W] == min_p0) begin
      best_p0 = 2'd1;
    end else if (new_p0[2*PM_W +: PM_W] == min_p0) begin
      best_p0 = 2'd2;
    end else begin
      best_p0 = 2'd3;
    end
    norm_p0 = '0;
    for (int n = 0; n < 4; n++) begin
      norm_p0[PM_W*n +: PM_W] = new_p0[PM_W*n +: PM_W] - min_p0;
    end
  end

  // Stage p1: commit one trellis step per enabled cycle; reset restores frame-start metrics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pm_p1   <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      surv_p1 <= '0;
      best_p1 <= '0;
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= en_add;
      if (en_add) begin
        pm_p1   <= norm_p0;
        surv_p1 <= surv_p0;
        best_p1 <= best_p0;
        cnt_p1  <= i_start ? 16'd1 : sat_inc(cnt_p1);
      end
    end
  end

  assign o_pm         = pm_p1;
  assign o_survivor   = surv_p1;
  assign o_best_state = best_p1;
  assign o_step_cnt   = cnt_p1;
  assign o_valid      = vld_p1;

endmodule
